spi_arbiter: RTL and testbench

SPI_ARBITER -- requirements
Module: spi_arbiter

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_arbiter_if.sv | 32 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/spi_arbiter.sv | 126 ++++++++++++
 tb/tb_spi_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction arbiter.
//   SPI_BYTE_W : width of one SPI transfer byte
//   state_e    : transaction FSM state encoding
package spi_pkg;

    localparam int unsigned SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitLow,
        StWaitHigh,
        StCapture,
        StResp
    } state_e;

endpackage

// File: rtl/spi_arbiter_if.sv
// Bus bundle between N_REQ requesters, the arbiter and one SPI driver.
//   Requester side : req, req_data (in); gnt, rsp_valid, rsp_data, rsp_err, busy (out)
//   Driver side    : drv_start, drv_data_in (out); drv_spi_en, drv_data_out (in)
// The 'slave' modport is the arbiter's view; 'master' is the environment's view.
interface spi_arbiter_if #(
    parameter int unsigned N_REQ = 4
) ();
    import spi_pkg::*;

    logic [N_REQ-1:0]            req;
    logic [SPI_BYTE_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]            gnt;
    logic [N_REQ-1:0]            rsp_valid;
    logic [SPI_BYTE_W-1:0]       rsp_data;
    logic                        rsp_err;
    logic                        busy;
    logic                        drv_start;
    logic [SPI_BYTE_W-1:0]       drv_data_in;
    logic                        drv_spi_en;
    logic [SPI_BYTE_W-1:0]       drv_data_out;

    modport slave (
        input  req, req_data, drv_spi_en, drv_data_out,
        output gnt, rsp_valid, rsp_data, rsp_err, busy, drv_start, drv_data_in
    );

    modport master (
        output req, req_data, drv_spi_en, drv_data_out,
        input  gnt, rsp_valid, rsp_data, rsp_err, busy, drv_start, drv_data_in
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner selection.
//   req_i   : request vector
//   last_i  : index of the previous winner; search starts just above it
//   idx_o   : index of the next winner (last_i when nobody requests)
//   valid_o : at least one request present
module rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_i,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic                     valid_o
);
    localparam int unsigned IdxW = $clog2(N_REQ);

    int unsigned cand;

    always_comb begin
        idx_o   = last_i;
        valid_o = 1'b0;
        cand    = 0;
        // Walk last+1, last+2, ... wrapping; the first hit wins.
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(last_i) + k) % N_REQ;
            if (!valid_o && req_i[IdxW'(cand)]) begin
                idx_o   = IdxW'(cand);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Arbitrates N_REQ requesters onto one SPI driver, one byte transaction at a time.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : spi_arbiter_if slave modport (requester and driver signals)
// The driver's active-low slave select is used as a progress indicator: a
// transfer is done once it has gone low and come back high. A watchdog ends
// any transaction that stalls for TIMEOUT cycles with rsp_err set.
// N_REQ must match the N_REQ of the connected interface.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input logic          clk,
    input logic          rst_n,
    spi_arbiter_if.slave bus
);
    localparam int unsigned    IdxW    = $clog2(N_REQ);
    localparam int unsigned    WdW     = $clog2(TIMEOUT);
    localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [IdxW-1:0]       winner_q, winner_d;
    logic [IdxW-1:0]       last_q, last_d;
    logic [WdW-1:0]        wd_q, wd_d;
    logic [SPI_BYTE_W-1:0] tx_q, tx_d;
    logic [SPI_BYTE_W-1:0] rx_q, rx_d;
    logic                  err_q, err_d;

    logic [IdxW-1:0]       arb_idx;
    logic                  arb_valid;
    logic [N_REQ-1:0]      winner_oh;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req_i   (bus.req),
        .last_i  (last_q),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        wd_d     = wd_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        err_d    = err_q;

        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d  = StStart;
                    winner_d = arb_idx;
                    last_d   = arb_idx;
                    wd_d     = '0;
                    err_d    = 1'b0;
                    // TX byte is latched here so later req_data changes are ignored.
                    for (int i = 0; i < int'(N_REQ); i++) begin
                        if (arb_idx == IdxW'(i)) begin
                            tx_d = bus.req_data[i*SPI_BYTE_W +: SPI_BYTE_W];
                        end
                    end
                end
            end
            StStart: state_d = StWaitLow;
            StWaitLow, StWaitHigh: begin
                // Watchdog expiry takes priority over any slave-select edge.
                if (wd_q == WdLimit) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    rx_d    = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (state_q == StWaitLow && !bus.drv_spi_en) begin
                        state_d = StWaitHigh;
                    end else if (state_q == StWaitHigh && bus.drv_spi_en) begin
                        state_d = StCapture;
                    end
                end
            end
            StCapture: begin
                rx_d    = bus.drv_data_out;
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            winner_q <= '0;
            last_q   <= IdxW'(N_REQ - 1);
            wd_q     <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            wd_q     <= wd_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        winner_oh           = '0;
        winner_oh[winner_q] = 1'b1;
    end

    assign bus.gnt         = (state_q != StIdle) ? winner_oh : '0;
    assign bus.rsp_valid   = (state_q == StResp) ? winner_oh : '0;
    assign bus.rsp_data    = rx_q;
    assign bus.rsp_err     = err_q && (state_q == StResp);
    assign bus.busy        = (state_q != StIdle);
    assign bus.drv_start   = (state_q == StStart);
    assign bus.drv_data_in = tx_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: a behavioural SPI slave, requesters
// driven from the main sequence, and a scoreboard of expected responses that
// a monitor pops on every rsp_valid.
module tb_spi_arbiter;
    import spi_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned TMO  = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_arbiter_if #(.N_REQ(NREQ)) bus ();

    spi_arbiter #(
        .N_REQ   (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       err;
        logic [7:0] tx;
    } exp_t;

    exp_t       sb[$];
    int         n_vec     = 0;
    int         n_err     = 0;
    int         cyc       = 0;
    int         pend[NREQ];
    int         n_start   = 0;
    int         start_cyc = 0;
    int         rsp_cyc   = 0;
    logic       slave_dead = 1'b0;
    logic [7:0] rx_xor     = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string p);
        check({p, "_gnt"},         32'(bus.gnt),         0);
        check({p, "_rsp_valid"},   32'(bus.rsp_valid),   0);
        check({p, "_rsp_data"},    32'(bus.rsp_data),    0);
        check({p, "_rsp_err"},     32'(bus.rsp_err),     0);
        check({p, "_busy"},        32'(bus.busy),        0);
        check({p, "_drv_start"},   32'(bus.drv_start),   0);
        check({p, "_drv_data_in"}, 32'(bus.drv_data_in), 0);
    endtask

    task automatic expect_rsp(input int i, input logic [7:0] d, input logic e, input logic [7:0] t);
        exp_t x;
        x.idx = i; x.data = d; x.err = e; x.tx = t;
        sb.push_back(x);
    endtask

    task automatic issue(input int i, input logic [7:0] d, input int n);
        bus.req_data[i*8 +: 8] = d;
        pend[i]                = n;
        bus.req[i]             = 1'b1;
    endtask

    task automatic wait_idle(input int max);
        int k = 0;
        while ((sb.size() != 0 || bus.busy !== 1'b0) && k < max) begin
            @(negedge clk);
            k++;
        end
        if (k >= max) check("drain_pending", 32'(sb.size()) + 32'(bus.busy), 0);
    endtask

    task automatic wait_sb(input int n, input int max);
        int k = 0;
        while (sb.size() > n && k < max) begin
            @(negedge clk);
            k++;
        end
        if (k >= max) check("sb_wait", 32'(sb.size()), 32'(n));
    endtask

    task automatic wait_start(input int max);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.drv_start !== 1'b1 && k < max);
        if (bus.drv_start !== 1'b1) check("start_wait", 32'(bus.drv_start), 1);
    endtask

    // SPI slave: select low two cycles after the start strobe, high three
    // cycles later with the looped-back byte (optionally XOR-scrambled).
    initial begin
        logic [7:0] b;
        bus.drv_spi_en   = 1'b1;
        bus.drv_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.drv_start === 1'b1 && !slave_dead) begin
                b = bus.drv_data_in;
                repeat (2) @(negedge clk);
                bus.drv_spi_en = 1'b0;
                repeat (3) @(negedge clk);
                bus.drv_data_out = b ^ rx_xor;
                bus.drv_spi_en   = 1'b1;
            end
        end
    end

    // Response monitor and scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.drv_start === 1'b1) begin
                n_start++;
                start_cyc = cyc;
            end
            if ($countones(bus.gnt) > 1) check("gnt_onehot", 32'($countones(bus.gnt)), 1);
            if (bus.rsp_valid !== '0) begin
                rsp_cyc = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'(bus.rsp_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_valid",   32'(bus.rsp_valid),   32'(1) << e.idx);
                    check("gnt",         32'(bus.gnt),         32'(1) << e.idx);
                    check("rsp_data",    32'(bus.rsp_data),    32'(e.data));
                    check("rsp_err",     32'(bus.rsp_err),     32'(e.err));
                    check("drv_data_in", 32'(bus.drv_data_in), 32'(e.tx));
                end
                for (int i = 0; i < int'(NREQ); i++) begin
                    if (bus.rsp_valid[i] === 1'b1) begin
                        pend[i]--;
                        if (pend[i] <= 0) bus.req[i] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int req_cyc;
        int s0;
        int r0;
        bus.req      = '0;
        bus.req_data = '0;
        for (int i = 0; i < int'(NREQ); i++) pend[i] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Single request with loopback
        s0      = n_start;
        req_cyc = cyc;
        expect_rsp(2, 8'hA5, 1'b0, 8'hA5);
        issue(2, 8'hA5, 1);
        wait_idle(100);
        // START at +1, select low seen at +3, high seen at +6, RESP at +8
        check("single_latency", 32'(rsp_cyc - req_cyc), 8);
        check("single_starts",  32'(n_start - s0),      1);

        // Round-robin from reset: order 0,1,2,3,0
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rx_xor = 8'h5A;
        expect_rsp(0, 8'hA0 ^ 8'h5A, 1'b0, 8'hA0);
        expect_rsp(1, 8'hB1 ^ 8'h5A, 1'b0, 8'hB1);
        expect_rsp(2, 8'hC2 ^ 8'h5A, 1'b0, 8'hC2);
        expect_rsp(3, 8'hD3 ^ 8'h5A, 1'b0, 8'hD3);
        expect_rsp(0, 8'hA0 ^ 8'h5A, 1'b0, 8'hA0);
        issue(0, 8'hA0, 2);
        issue(1, 8'hB1, 1);
        issue(2, 8'hC2, 1);
        issue(3, 8'hD3, 1);
        wait_idle(400);
        rx_xor = 8'h00;

        // TX byte held after grant
        expect_rsp(1, 8'h3C, 1'b0, 8'h3C);
        issue(1, 8'h3C, 1);
        wait_start(20);
        @(negedge clk);
        bus.req_data[15:8] = 8'hFF;
        wait_idle(100);

        // Late request: granted after RESP plus one IDLE cycle
        expect_rsp(0, 8'h11, 1'b0, 8'h11);
        issue(0, 8'h11, 1);
        wait_start(20);
        repeat (2) @(negedge clk);
        expect_rsp(3, 8'h33, 1'b0, 8'h33);
        issue(3, 8'h33, 1);
        wait_sb(1, 100);
        r0 = rsp_cyc;
        wait_idle(100);
        check("late_gap", 32'(start_cyc - r0), 2);

        // Watchdog timeout with a dead slave
        slave_dead = 1'b1;
        req_cyc    = cyc;
        expect_rsp(2, 8'h00, 1'b1, 8'h77);
        issue(2, 8'h77, 1);
        wait_idle(200);
        // START at +1, 64 wait cycles, RESP at +66
        check("timeout_latency", 32'(rsp_cyc - req_cyc), 66);
        slave_dead = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during WAIT_HIGH: no response, outputs cleared at once
        issue(1, 8'h5C, 1);
        begin
            int k = 0;
            while (bus.drv_spi_en !== 1'b0 && k < 30) begin
                @(negedge clk);
                k++;
            end
            if (k >= 30) check("spi_en_low_wait", 32'(bus.drv_spi_en), 0);
        end
        @(negedge clk);
        check("pre_reset_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset("midop");
        bus.req = '0;
        pend[1] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        // Priority restarts at requester 0 (pre-reset pointer would pick 2)
        expect_rsp(0, 8'hE0, 1'b0, 8'hE0);
        expect_rsp(2, 8'hE2, 1'b0, 8'hE2);
        issue(0, 8'hE0, 1);
        issue(2, 8'hE2, 1);
        wait_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
